// File: rtl/core_pkg.sv
// Shared definitions for the attention-core sequencer: inst word bit positions and FSM encoding.
package core_pkg;

    localparam int INST_W           = 17;
    localparam int INST_OFIFO_RD    = 16;
    localparam int INST_QK_ADDR_LSB = 12;
    localparam int INST_P_ADDR_LSB  = 8;
    localparam int INST_EXEC        = 7;
    localparam int INST_KLOAD       = 6;
    localparam int INST_QRD         = 5;
    localparam int INST_QWR         = 4;
    localparam int INST_KRD         = 3;
    localparam int INST_KWR         = 2;
    localparam int INST_PRD         = 1;
    localparam int INST_PWR         = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_Q = 3'd1,
        ST_LOAD_K = 3'd2,
        ST_KLOAD  = 3'd3,
        ST_KWAIT  = 3'd4,
        ST_EXEC   = 3'd5,
        ST_DRAIN  = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

endpackage

// File: rtl/core_seq.sv
// Sequencer for one Q*K pass of the attention core: loads qmem/kmem, loads kernels, executes, drains ofifo.
// Latency: every output is registered; MAC bits trail their SRAM reads by one cycle.
// Backpressure: in_ready only in the load states, stalls on in_valid=0; drain stalls on fifo_valid=0.
module core_seq
    import core_pkg::*;
#(
    parameter int COL   = 8,
    parameter int BW    = 8,
    parameter int PR    = 16,
    parameter int KWAIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4:0]         nq,
    input  logic [PR*BW-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               fifo_valid,
    output logic [PR*BW-1:0]   mem_in,
    output logic [INST_W-1:0]  inst,
    output logic               busy,
    output logic               done
);

    localparam int WCW = $clog2(KWAIT + 1);

    state_t              state_q, state_d;
    logic [4:0]          nq_q, nq_d;
    logic [4:0]          idx_q, idx_d;
    logic [4:0]          pcnt_q, pcnt_d;
    logic [WCW-1:0]      wcnt_q, wcnt_d;
    logic [PR*BW-1:0]    mem_in_q, mem_in_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dly_exec_q, dly_exec_d;
    logic                dly_kload_q, dly_kload_d;
    logic                dly_pwr_q, dly_pwr_d;
    logic [3:0]          dly_paddr_q, dly_paddr_d;

    logic xfer, last_q, last_col, drain_en, rd_issue;

    always_comb begin
        state_d     = state_q;
        nq_d        = nq_q;
        idx_d       = idx_q;
        pcnt_d      = pcnt_q;
        wcnt_d      = wcnt_q;
        mem_in_d    = mem_in_q;
        // Address fields hold across idle/stall cycles; only the strobe bits self-clear.
        inst_d      = inst_q;
        inst_d[INST_OFIFO_RD] = 1'b0;
        inst_d[7:0] = '0;
        dly_exec_d  = 1'b0;
        dly_kload_d = 1'b0;
        dly_pwr_d   = 1'b0;
        dly_paddr_d = dly_paddr_q;

        xfer     = in_valid & in_ready_q;
        last_q   = (idx_q == nq_q - 5'd1);
        last_col = (idx_q == 5'(COL - 1));
        drain_en = (state_q == ST_EXEC) || (state_q == ST_DRAIN);
        rd_issue = drain_en && fifo_valid && (pcnt_q < nq_q);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (nq == 5'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        nq_d    = nq;
                        idx_d   = '0;
                        pcnt_d  = '0;
                        state_d = ST_LOAD_Q;
                    end
                end
            end
            ST_LOAD_Q: begin
                if (xfer) begin
                    mem_in_d                          = in_data;
                    inst_d[INST_QWR]                  = 1'b1;
                    inst_d[INST_QK_ADDR_LSB +: 4]     = idx_q[3:0];
                    if (last_q) begin
                        idx_d   = '0;
                        state_d = ST_LOAD_K;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_LOAD_K: begin
                if (xfer) begin
                    mem_in_d                          = in_data;
                    inst_d[INST_KWR]                  = 1'b1;
                    inst_d[INST_QK_ADDR_LSB +: 4]     = idx_q[3:0];
                    if (last_col) begin
                        idx_d   = '0;
                        state_d = ST_KLOAD;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_KLOAD: begin
                inst_d[INST_KRD]              = 1'b1;
                inst_d[INST_QK_ADDR_LSB +: 4] = idx_q[3:0];
                dly_kload_d                   = 1'b1;
                if (last_col) begin
                    idx_d   = '0;
                    wcnt_d  = '0;
                    state_d = ST_KWAIT;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            ST_KWAIT: begin
                // The first cycle here carries the last kernel-load bit, so the
                // count runs one past KWAIT to leave KWAIT fully idle cycles.
                if (wcnt_q == WCW'(KWAIT)) begin
                    state_d = ST_EXEC;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_EXEC: begin
                inst_d[INST_QRD]              = 1'b1;
                inst_d[INST_QK_ADDR_LSB +: 4] = idx_q[3:0];
                dly_exec_d                    = 1'b1;
                if (last_q) begin
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            ST_DRAIN: begin
                if ((pcnt_q == nq_q) || (rd_issue && (pcnt_q == nq_q - 5'd1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_issue) begin
            inst_d[INST_OFIFO_RD] = 1'b1;
            pcnt_d                = pcnt_q + 5'd1;
            dly_pwr_d             = 1'b1;
            dly_paddr_d           = pcnt_q[3:0];
        end

        inst_d[INST_EXEC]  = dly_exec_q;
        inst_d[INST_KLOAD] = dly_kload_q;
        if (dly_pwr_q) begin
            inst_d[INST_PWR]             = 1'b1;
            inst_d[INST_P_ADDR_LSB +: 4] = dly_paddr_q;
        end

        in_ready_d = (state_d == ST_LOAD_Q) || (state_d == ST_LOAD_K);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            nq_q        <= '0;
            idx_q       <= '0;
            pcnt_q      <= '0;
            wcnt_q      <= '0;
            mem_in_q    <= '0;
            inst_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dly_exec_q  <= 1'b0;
            dly_kload_q <= 1'b0;
            dly_pwr_q   <= 1'b0;
            dly_paddr_q <= '0;
        end else begin
            state_q     <= state_d;
            nq_q        <= nq_d;
            idx_q       <= idx_d;
            pcnt_q      <= pcnt_d;
            wcnt_q      <= wcnt_d;
            mem_in_q    <= mem_in_d;
            inst_q      <= inst_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dly_exec_q  <= dly_exec_d;
            dly_kload_q <= dly_kload_d;
            dly_pwr_q   <= dly_pwr_d;
            dly_paddr_q <= dly_paddr_d;
        end
    end

    assign in_ready = in_ready_q;
    assign mem_in   = mem_in_q;
    assign inst     = inst_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: stalls, mid-pass reset, full passes at nq=4/0/16, start ignored in EXEC.
module tb_core_seq;
    import core_pkg::*;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, fifo_valid;
    logic [4:0]    nq;
    logic [DW-1:0] in_data;
    logic          in_ready, busy, done;
    logic [DW-1:0] mem_in;
    logic [16:0]   inst;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    core_seq #(.COL(8), .BW(8), .PR(16), .KWAIT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .nq(nq),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fifo_valid(fifo_valid), .mem_in(mem_in), .inst(inst),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

    function automatic logic [DW-1:0] mk(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 + i;
        return {4{w}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0]  vpat;
        logic [16:0] stall_exp [4];
        int          qrd;

        reset = 1'b1; start = 1'b0; nq = '0; in_data = '0; in_valid = 1'b0; fifo_valid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst inst", inst, 0);
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst done", done, 0);
        chk("rst mem_in", mem_in, 0);

        // Stalled Q loading, then reset in the middle of LOAD_K
        start = 1'b1; nq = 5'd2; step(); start = 1'b0;
        chk("start busy", busy, 1);
        chk("start in_ready", in_ready, 1);
        vpat = 4'b1001;
        stall_exp[0] = 17'h00010; stall_exp[1] = 17'h00000;
        stall_exp[2] = 17'h00000; stall_exp[3] = 17'h01010;
        for (int i = 0; i < 4; i++) begin
            in_valid = vpat[3 - i]; in_data = mk(i);
            step();
            chk("stall inst", inst, stall_exp[i]);
        end
        chk("stall mem_in", mem_in, mk(3));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = mk(10 + i);
            step();
            chk("kwr pre-reset", inst, (i << 12) | 17'h4);
        end
        in_valid = 1'b0; reset = 1'b1;
        repeat (3) step();
        chk("midrst inst", inst, 0);
        chk("midrst busy", busy, 0);
        chk("midrst in_ready", in_ready, 0);
        chk("midrst state", dut.state_q, ST_IDLE);
        reset = 1'b0;
        step();

        // Full pass nq=4, with a stray start during EXEC
        start = 1'b1; nq = 5'd4; step(); start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = mk(20 + i);
            step();
            chk("qwr inst", inst, (i << 12) | 17'h10);
            chk("qwr mem_in", mem_in, mk(20 + i));
        end
        for (int i = 0; i < 8; i++) begin
            in_data = mk(30 + i);
            step();
            chk("kwr inst", inst, (i << 12) | 17'h4);
            chk("kwr in_ready", in_ready, (i < 7) ? 1 : 0);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("krd inst", inst, (i << 12) | 17'h8 | ((i > 0) ? 17'h40 : 17'h0));
        end
        step();
        chk("last kload", inst, 17'h07040);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("kwait idle", inst, 17'h07000);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk("qrd inst", inst, (i << 12) | 17'h20 | ((i > 0) ? 17'h80 : 17'h0));
            if (i == 0) begin start = 1'b1; nq = 5'd9; end else start = 1'b0;
        end
        step();
        chk("last exec", inst, 17'h03080);
        step();
        chk("drain idle", inst, 17'h03000);
        chk("drain busy", busy, 1);
        fifo_valid = 1'b1;
        step(); chk("drain rd0", inst, 17'h13000);
        step(); chk("drain rd1 wr0", inst, 17'h13001);
        step(); chk("drain rd2 wr1", inst, 17'h13101);
        step(); chk("drain rd3 wr2", inst, 17'h13201);
        fifo_valid = 1'b0;
        step();
        chk("final pwr", inst, 17'h03301);
        chk("done pulse", done, 1);
        chk("busy at done", busy, 0);
        step();
        chk("post done inst", inst, 17'h03300);
        chk("done low", done, 0);
        chk("done count nq4", done_cnt, 1);

        // nq=0 goes straight to DONE
        start = 1'b1; nq = 5'd0; step(); start = 1'b0;
        chk("nq0 done early", done, 0);
        chk("nq0 busy", busy, 1);
        step();
        chk("nq0 done", done, 1);
        chk("nq0 no mem bits", inst & 17'h100FF, 0);
        step();
        chk("done count nq0", done_cnt, 2);

        // nq=16: full address range, long drain stall
        start = 1'b1; nq = 5'd16; step(); start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = mk(40 + i);
            step();
            chk("q16 wr", inst & 17'h0F0FF, ((i % 16) << 12) | 17'h10);
        end
        for (int i = 0; i < 8; i++) begin
            in_data = mk(60 + i);
            step();
        end
        chk("q16 kwr last", inst & 17'h0F0FF, 17'h07004);
        in_valid = 1'b0;
        qrd = 0;
        for (int c = 0; c < 200 && dut.state_q != ST_DRAIN; c++) begin
            step();
            if (inst[INST_QRD]) begin
                chk("q16 rd addr", inst[15:12], qrd % 16);
                qrd++;
            end
        end
        chk("q16 rd count", qrd, 16);
        repeat (20) step();
        chk("q16 stall state", dut.state_q, ST_DRAIN);
        chk("q16 stall busy", busy, 1);
        fifo_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            chk("q16 drain bits", {inst[INST_OFIFO_RD], inst[INST_PWR]},
                {(i < 16) ? 1'b1 : 1'b0, (i >= 1) ? 1'b1 : 1'b0});
            if (i >= 1) chk("q16 paddr", inst[11:8], (i - 1) % 16);
        end
        chk("q16 done", done, 1);
        fifo_valid = 1'b0;
        step();
        chk("done count nq16", done_cnt, 3);
        chk("q16 idle busy", busy, 0);

        // Next pass restarts Q addressing at 0
        start = 1'b1; nq = 5'd1; step(); start = 1'b0;
        in_valid = 1'b1; in_data = mk(99);
        step();
        chk("wrap qwr", inst & 17'h0F0FF, 17'h00010);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
